// File: rtl/cache_pkg.sv
// Shared sizes and types for the set-associative L1 tag lookup.
package cache_pkg;

    localparam int OFFSET_SIZE = 5;
    localparam int INDEX_SIZE  = 6;
    localparam int TAG_SIZE    = 64 - (OFFSET_SIZE + INDEX_SIZE);
    localparam int NUM_WAYS    = 4;
    localparam int WAY_SIZE    = $clog2(NUM_WAYS);

    typedef logic [WAY_SIZE-1:0] way_t;

    typedef struct packed {
        logic [TAG_SIZE-1:0]    tag;
        logic [INDEX_SIZE-1:0]  index;
        logic [OFFSET_SIZE-1:0] offset;
    } req_t;

endpackage

// File: rtl/tag_way_compare.sv
// Combinational probe of one set: tag match across ways plus lowest invalid way.
module tag_way_compare
    import cache_pkg::*;
#(
    parameter int tagSize = TAG_SIZE,
    parameter int numWays = NUM_WAYS,
    parameter int waySize = $clog2(numWays)
) (
    input  logic [tagSize-1:0] tags_i [numWays],
    input  logic [numWays-1:0] valid_i,
    input  logic [tagSize-1:0] tag_i,
    output logic               hit_o,
    output logic [waySize-1:0] hitWay_o,
    output logic               anyInvalid_o,
    output logic [waySize-1:0] firstInvalid_o,
    output logic [numWays-1:0] match_o
);

    always_comb begin
        match_o        = '0;
        hitWay_o       = '0;
        firstInvalid_o = '0;
        for (int w = 0; w < numWays; w++) begin
            match_o[w] = valid_i[w] && (tags_i[w] == tag_i);
            if (match_o[w]) begin
                hitWay_o = waySize'(w);
            end
        end
        // descending scan so the lowest-numbered invalid way wins
        for (int w = numWays - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                firstInvalid_o = waySize'(w);
            end
        end
        hit_o        = |match_o;
        anyInvalid_o = ~&valid_i;
    end

endmodule

// File: rtl/cache_tag_query_assoc.sv
// N-way set-associative tag query: two-stage lookup over snapshotted set state,
// with round-robin fill, flush, stall and flash-invalidate.
module cache_tag_query_assoc
    import cache_pkg::*;
#(
    parameter int offsetSize = OFFSET_SIZE,
    parameter int indexSize  = INDEX_SIZE,
    parameter int tagSize    = 64 - (offsetSize + indexSize),
    parameter int numWays    = NUM_WAYS,
    parameter int waySize    = $clog2(numWays)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  fetchEnable_i,
    input  logic [tagSize-1:0]    tag_i,
    input  logic [indexSize-1:0]  index_i,
    input  logic [offsetSize-1:0] offset_i,
    output logic                  fetchReady_o,
    input  logic                  stall_i,
    input  logic                  flushPipeline_i,
    input  logic                  invalidateAll_i,
    input  logic                  updateEnable_i,
    input  logic [tagSize-1:0]    newTag_i,
    input  logic [indexSize-1:0]  newIndex_i,
    output logic                  enable_o,
    output logic [tagSize-1:0]    tag_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o,
    output logic                  hit_o,
    output logic [waySize-1:0]    hitWay_o,
    output logic [waySize-1:0]    victimWay_o
);

    localparam int numSets = 1 << indexSize;

    logic accept;

    logic [tagSize-1:0] tag_q   [numSets][numWays];
    logic [tagSize-1:0] tag_d   [numSets][numWays];
    logic [numWays-1:0] valid_q [numSets];
    logic [numWays-1:0] valid_d [numSets];
    logic [waySize-1:0] ptr_q   [numSets];
    logic [waySize-1:0] ptr_d   [numSets];

    logic [tagSize-1:0] fill_tags [numWays];
    logic               fill_hit;
    logic [waySize-1:0] fill_hit_way;
    logic               fill_any_inv;
    logic [waySize-1:0] fill_first_inv;
    logic [numWays-1:0] fill_match;
    logic [waySize-1:0] fill_way;

    logic                  s1_valid_q, s1_valid_d;
    logic [tagSize-1:0]    s1_tag_q, s1_tag_d;
    logic [indexSize-1:0]  s1_index_q, s1_index_d;
    logic [offsetSize-1:0] s1_offset_q, s1_offset_d;
    logic [tagSize-1:0]    s1_tags_q [numWays];
    logic [tagSize-1:0]    s1_tags_d [numWays];
    logic [numWays-1:0]    s1_vbits_q, s1_vbits_d;
    logic [waySize-1:0]    s1_ptr_q, s1_ptr_d;

    logic               s2_hit;
    logic [waySize-1:0] s2_hit_way;
    logic               s2_unused_any_inv;
    logic [waySize-1:0] s2_unused_first_inv;
    logic [numWays-1:0] s2_match;

    logic                  en_q, en_d;
    logic                  hit_q, hit_d;
    logic [waySize-1:0]    hit_way_q, hit_way_d;
    logic [waySize-1:0]    victim_q, victim_d;
    logic [tagSize-1:0]    tag_out_q, tag_out_d;
    logic [indexSize-1:0]  index_out_q, index_out_d;
    logic [offsetSize-1:0] offset_out_q, offset_out_d;

    assign fetchReady_o = !stall_i && !updateEnable_i && !invalidateAll_i && !flushPipeline_i;
    assign accept       = fetchEnable_i && fetchReady_o;

    always_comb begin
        for (int w = 0; w < numWays; w++) begin
            fill_tags[w] = tag_q[newIndex_i][w];
        end
    end

    tag_way_compare #(.tagSize(tagSize), .numWays(numWays), .waySize(waySize)) u_fill_cmp (
        .tags_i         (fill_tags),
        .valid_i        (valid_q[newIndex_i]),
        .tag_i          (newTag_i),
        .hit_o          (fill_hit),
        .hitWay_o       (fill_hit_way),
        .anyInvalid_o   (fill_any_inv),
        .firstInvalid_o (fill_first_inv),
        .match_o        (fill_match)
    );

    // Refill of a resident tag reuses its way; only a full-set miss advances the pointer.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (fill_hit) begin
            fill_way = fill_hit_way;
        end else if (fill_any_inv) begin
            fill_way = fill_first_inv;
        end else begin
            fill_way = ptr_q[newIndex_i];
        end
        if (invalidateAll_i) begin
            for (int s = 0; s < numSets; s++) begin
                valid_d[s] = '0;
            end
        end else if (updateEnable_i) begin
            tag_d[newIndex_i][fill_way]   = newTag_i;
            valid_d[newIndex_i][fill_way] = 1'b1;
            if (!fill_hit && !fill_any_inv) begin
                ptr_d[newIndex_i] = ptr_q[newIndex_i] + waySize'(1);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_index_d  = s1_index_q;
        s1_offset_d = s1_offset_q;
        s1_tags_d   = s1_tags_q;
        s1_vbits_d  = s1_vbits_q;
        s1_ptr_d    = s1_ptr_q;
        if (flushPipeline_i) begin
            s1_valid_d = 1'b0;
        end else if (!stall_i) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_tag_d    = tag_i;
                s1_index_d  = index_i;
                s1_offset_d = offset_i;
                for (int w = 0; w < numWays; w++) begin
                    s1_tags_d[w] = tag_q[index_i][w];
                end
                s1_vbits_d  = valid_q[index_i];
                s1_ptr_d    = ptr_q[index_i];
            end
        end
    end

    tag_way_compare #(.tagSize(tagSize), .numWays(numWays), .waySize(waySize)) u_s2_cmp (
        .tags_i         (s1_tags_q),
        .valid_i        (s1_vbits_q),
        .tag_i          (s1_tag_q),
        .hit_o          (s2_hit),
        .hitWay_o       (s2_hit_way),
        .anyInvalid_o   (s2_unused_any_inv),
        .firstInvalid_o (s2_unused_first_inv),
        .match_o        (s2_match)
    );

    always_comb begin
        en_d         = en_q;
        hit_d        = hit_q;
        hit_way_d    = hit_way_q;
        victim_d     = victim_q;
        tag_out_d    = tag_out_q;
        index_out_d  = index_out_q;
        offset_out_d = offset_out_q;
        if (flushPipeline_i) begin
            en_d = 1'b0;
        end else if (!stall_i) begin
            en_d         = s1_valid_q;
            hit_d        = s1_valid_q && s2_hit;
            hit_way_d    = s2_hit_way;
            victim_d     = s1_ptr_q;
            tag_out_d    = s1_tag_q;
            index_out_d  = s1_index_q;
            offset_out_d = s1_offset_q;
        end
    end

    // Tag storage needs no reset: every way is qualified by its valid bit.
    always_ff @(posedge clock_i) begin
        tag_q <= tag_d;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < numSets; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_index_q  <= '0;
            s1_offset_q <= '0;
            for (int w = 0; w < numWays; w++) begin
                s1_tags_q[w] <= '0;
            end
            s1_vbits_q   <= '0;
            s1_ptr_q     <= '0;
            en_q         <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            victim_q     <= '0;
            tag_out_q    <= '0;
            index_out_q  <= '0;
            offset_out_q <= '0;
        end else begin
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            s1_index_q   <= s1_index_d;
            s1_offset_q  <= s1_offset_d;
            s1_tags_q    <= s1_tags_d;
            s1_vbits_q   <= s1_vbits_d;
            s1_ptr_q     <= s1_ptr_d;
            en_q         <= en_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
            victim_q     <= victim_d;
            tag_out_q    <= tag_out_d;
            index_out_q  <= index_out_d;
            offset_out_q <= offset_out_d;
        end
    end

    a_single_match_lookup: assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(s2_match));
    a_single_match_fill:   assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(fill_match));

    assign enable_o    = en_q;
    assign hit_o       = hit_q;
    assign hitWay_o    = hit_way_q;
    assign victimWay_o = victim_q;
    assign tag_o       = tag_out_q;
    assign index_o     = index_out_q;
    assign offset_o    = offset_out_q;

endmodule

// File: tb/tb_cache_tag_query_assoc.sv
// Bench for cache_tag_query_assoc: directed vectors against a set-level model plus literal pins.
module tb_cache_tag_query_assoc;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fe, stall, flush, inv, upd;
    logic [52:0] tag, ntag;
    logic [5:0]  idx, nidx;
    logic [4:0]  off;
    logic        fetchReady_o, enable_o, hit_o;
    logic [52:0] tag_o;
    logic [5:0]  index_o;
    logic [4:0]  offset_o;
    logic [1:0]  hitWay_o, victimWay_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic hit;
        way_t way;
        way_t victim;
        req_t req;
    } res_t;

    logic [52:0] m_tag   [64][4];
    logic [3:0]  m_valid [64];
    logic [1:0]  m_ptr   [64];
    logic        m_s1v, m_en;
    res_t        m_s1, m_out;

    always #5 clk = ~clk;

    cache_tag_query_assoc dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .fetchEnable_i   (fe),
        .tag_i           (tag),
        .index_i         (idx),
        .offset_i        (off),
        .fetchReady_o    (fetchReady_o),
        .stall_i         (stall),
        .flushPipeline_i (flush),
        .invalidateAll_i (inv),
        .updateEnable_i  (upd),
        .newTag_i        (ntag),
        .newIndex_i      (nidx),
        .enable_o        (enable_o),
        .tag_o           (tag_o),
        .index_o         (index_o),
        .offset_o        (offset_o),
        .hit_o           (hit_o),
        .hitWay_o        (hitWay_o),
        .victimWay_o     (victimWay_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_valid[s] = '0;
            m_ptr[s]   = '0;
        end
        m_s1v = 1'b0;
        m_en  = 1'b0;
        m_s1  = '0;
        m_out = '0;
    endtask

    function automatic res_t model_lookup(input logic [52:0] t, input logic [5:0] i, input logic [4:0] o);
        res_t r;
        r            = '0;
        r.req.tag    = t;
        r.req.index  = i;
        r.req.offset = o;
        r.victim     = m_ptr[i];
        for (int w = 0; w < 4; w++) begin
            if (m_valid[i][w] && m_tag[i][w] == t) begin
                r.hit = 1'b1;
                r.way = 2'(w);
            end
        end
        return r;
    endfunction

    task automatic model_fill(input logic [52:0] t, input logic [5:0] i);
        int target;
        target = -1;
        for (int w = 0; w < 4; w++) begin
            if (target < 0 && m_valid[i][w] && m_tag[i][w] == t) target = w;
        end
        for (int w = 0; w < 4; w++) begin
            if (target < 0 && !m_valid[i][w]) target = w;
        end
        if (target < 0) begin
            target   = m_ptr[i];
            m_ptr[i] = m_ptr[i] + 2'd1;
        end
        m_tag[i][target]   = t;
        m_valid[i][target] = 1'b1;
    endtask

    task automatic compare_outputs();
        chk("enable", 64'(enable_o), 64'(m_en));
        if (m_en) begin
            chk("hit", 64'(hit_o), 64'(m_out.hit));
            chk("hit_way", 64'(hitWay_o), 64'(m_out.way));
            chk("victim_way", 64'(victimWay_o), 64'(m_out.victim));
            chk("tag_echo", 64'(tag_o), 64'(m_out.req.tag));
            chk("index_echo", 64'(index_o), 64'(m_out.req.index));
            chk("offset_echo", 64'(offset_o), 64'(m_out.req.offset));
        end
    endtask

    // One clock: check ready, advance the model across the edge, compare on the falling edge.
    task automatic step();
        logic ready, acc;
        res_t r;
        #1;
        ready = !stall && !upd && !inv && !flush;
        chk("fetch_ready", 64'(fetchReady_o), 64'(ready));
        acc = fe && ready;
        r   = model_lookup(tag, idx, off);
        @(posedge clk);
        if (flush) begin
            m_s1v = 1'b0;
            m_en  = 1'b0;
        end else if (!stall) begin
            m_en  = m_s1v;
            m_out = m_s1;
            m_s1v = acc;
            if (acc) m_s1 = r;
        end
        if (inv) begin
            for (int s = 0; s < 64; s++) m_valid[s] = '0;
        end else if (upd) begin
            model_fill(ntag, nidx);
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle();
        fe = 0; stall = 0; flush = 0; inv = 0; upd = 0;
        tag = '0; idx = '0; off = '0; ntag = '0; nidx = '0;
    endtask

    task automatic fill(input logic [52:0] t, input logic [5:0] i);
        idle();
        upd = 1; ntag = t; nidx = i;
        step();
        idle();
    endtask

    task automatic lookup_one(input logic [52:0] t, input logic [5:0] i, input logic [4:0] o);
        idle();
        fe = 1; tag = t; idx = i; off = o;
        step();
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_enable", 64'(enable_o), 64'd0);
        chk("rst_hit", 64'(hit_o), 64'd0);
        chk("rst_hit_way", 64'(hitWay_o), 64'd0);
        chk("rst_victim", 64'(victimWay_o), 64'd0);
        chk("rst_tag", 64'(tag_o), 64'd0);
        chk("rst_index", 64'(index_o), 64'd0);
        chk("rst_offset", 64'(offset_o), 64'd0);
        rst = 0;
        step();

        // cold miss
        lookup_one(53'h123, 6'd5, 5'd7);
        chk("cold_enable", 64'(enable_o), 64'd1);
        chk("cold_hit", 64'(hit_o), 64'd0);
        chk("cold_victim", 64'(victimWay_o), 64'd0);

        // fill then hit
        fill(53'h123, 6'd5);
        lookup_one(53'h123, 6'd5, 5'h1f);
        chk("fill_hit", 64'(hit_o), 64'd1);
        chk("fill_hit_way", 64'(hitWay_o), 64'd0);
        chk("fill_offset", 64'(offset_o), 64'h1f);

        // round-robin: A..E into set 2, E evicts way 0
        for (int k = 0; k < 5; k++) fill(53'(10 + k), 6'd2);
        lookup_one(53'd10, 6'd2, 5'd0);
        chk("rr_a_miss", 64'(hit_o), 64'd0);
        chk("rr_victim", 64'(victimWay_o), 64'd1);
        lookup_one(53'd11, 6'd2, 5'd1);
        chk("rr_b_way", 64'(hitWay_o), 64'd1);
        lookup_one(53'd13, 6'd2, 5'd2);
        chk("rr_d_way", 64'(hitWay_o), 64'd3);
        lookup_one(53'd14, 6'd2, 5'd3);
        chk("rr_e_hit", 64'(hit_o), 64'd1);
        chk("rr_e_way", 64'(hitWay_o), 64'd0);

        // duplicate fill of C keeps way 2 and the pointer
        fill(53'd12, 6'd2);
        lookup_one(53'd12, 6'd2, 5'd4);
        chk("dup_c_way", 64'(hitWay_o), 64'd2);
        chk("dup_victim", 64'(victimWay_o), 64'd1);
        fill(53'd15, 6'd2);
        lookup_one(53'd15, 6'd2, 5'd5);
        chk("evict_f_way", 64'(hitWay_o), 64'd1);
        lookup_one(53'd11, 6'd2, 5'd6);
        chk("evict_b_miss", 64'(hit_o), 64'd0);
        chk("evict_victim", 64'(victimWay_o), 64'd2);

        // three back-to-back lookups, stall four cycles, then flush
        idle();
        fe = 1; tag = 53'h123; idx = 6'd5; off = 5'd1; step();
        tag = 53'd12; idx = 6'd2; off = 5'd2; step();
        tag = 53'd14; idx = 6'd2; off = 5'd3; step();
        tag = 53'h999; idx = 6'd9; stall = 1;
        repeat (4) step();
        chk("stall_enable", 64'(enable_o), 64'd1);
        chk("stall_way", 64'(hitWay_o), 64'd2);
        chk("stall_offset", 64'(offset_o), 64'd2);
        idle();
        flush = 1; step();
        chk("flush_enable", 64'(enable_o), 64'd0);
        idle();
        repeat (3) step();
        chk("flush_no_stale", 64'(enable_o), 64'd0);

        // invalidate wins over a simultaneous fill
        idle();
        inv = 1; upd = 1; ntag = 53'h777; nidx = 6'd9;
        step();
        lookup_one(53'h123, 6'd5, 5'd0);
        chk("inv_miss_123", 64'(hit_o), 64'd0);
        lookup_one(53'h777, 6'd9, 5'd0);
        chk("inv_fill_dropped", 64'(hit_o), 64'd0);
        lookup_one(53'd14, 6'd2, 5'd0);
        chk("inv_ptr_kept", 64'(victimWay_o), 64'd2);

        // request colliding with a fill is held off and retried
        idle();
        fe = 1; tag = 53'h555; idx = 6'd3; off = 5'd3;
        upd = 1; ntag = 53'h555; nidx = 6'd3;
        #1;
        chk("collide_ready", 64'(fetchReady_o), 64'd0);
        step();
        upd = 0;
        step();
        fe = 0;
        step();
        chk("retry_hit", 64'(hit_o), 64'd1);
        chk("retry_way", 64'(hitWay_o), 64'd0);

        // asynchronous reset in the middle of a result
        fill(53'h321, 6'd7);
        lookup_one(53'h321, 6'd7, 5'd9);
        chk("pre_rst_hit", 64'(hit_o), 64'd1);
        rst = 1;
        #1;
        chk("mid_rst_enable", 64'(enable_o), 64'd0);
        chk("mid_rst_hit", 64'(hit_o), 64'd0);
        chk("mid_rst_offset", 64'(offset_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        lookup_one(53'h321, 6'd7, 5'd9);
        chk("post_rst_miss", 64'(hit_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
